// File: rtl/mips_mem_pkg.sv
// Shared memory-path constants and the store buffer entry layout.
package mips_mem_pkg;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Combinational search of the queued stores for the youngest entry whose
// address equals the load address.
module sb_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [CW-1:0]     count,
    input  logic [AW-1:0]     ld_addr,
    output logic              hit,
    output logic [PW-1:0]     idx
);

    logic [PW-1:0] slot_s;
    logic          match_s;

    // Walk from the oldest entry forward; a later match overrides an earlier
    // one, which gives the same result as searching tail-1 back to head.
    always_comb begin
        hit     = 1'b0;
        idx     = head;
        slot_s  = head;
        match_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_s  = head + PW'(k);
            match_s = (CW'(k) < count) && (entries[slot_s].addr == ld_addr);
            hit     = hit | match_s;
            idx     = match_s ? slot_s : idx;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of the single-port data memory, with
// youngest-match load forwarding and load-first port arbitration.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = mips_mem_pkg::AW,
    parameter int DW    = mips_mem_pkg::DW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic [DW-1:0]              ld_data,
    output logic                       ld_hit,
    output logic                       ld_stall,
    output logic                       mem_write,
    output logic                       mem_read,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic [DW-1:0]              mem_rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t     entries_q [DEPTH];
    sb_entry_t     entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          m_hit_s;
    logic [PW-1:0] m_idx_s;
    logic          full_s;
    logic          empty_s;
    logic          rd_s;
    logic          pop_s;
    logic          push_s;

    sb_match #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_match (
        .entries (entries_q),
        .head    (head_q),
        .count   (count_q),
        .ld_addr (ld_addr),
        .hit     (m_hit_s),
        .idx     (m_idx_s)
    );

    // Port arbitration: a missing load owns the port unless the buffer is
    // full, in which case the head drains to make room for the retry.
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        empty_s  = (count_q == CW'(0));
        ld_hit   = ld_valid && m_hit_s;
        rd_s     = ld_valid && !m_hit_s && !full_s;
        ld_stall = ld_valid && !m_hit_s && full_s;
        pop_s    = !rd_s && !empty_s;
        push_s   = st_valid && !full_s;

        if (ld_hit) begin
            ld_data = entries_q[m_idx_s].data;
        end else if (rd_s) begin
            ld_data = mem_rdata;
        end else begin
            ld_data = {DW{1'b0}};
        end

        if (rd_s) begin
            mem_read  = 1'b1;
            mem_write = 1'b0;
            mem_addr  = ld_addr;
            mem_wdata = {DW{1'b0}};
        end else if (pop_s) begin
            mem_read  = 1'b0;
            mem_write = 1'b1;
            mem_addr  = entries_q[head_q].addr;
            mem_wdata = entries_q[head_q].data;
        end else begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
    end

    // Next-state for the FIFO storage, pointers and occupancy.
    always_comb begin
        entries_d = entries_q;
        if (push_s) begin
            entries_d[tail_q] = '{addr: st_addr, data: st_data};
        end else begin
            entries_d[tail_q] = entries_q[tail_q];
        end

        head_d = pop_s  ? (head_q + PW'(1)) : head_q;
        tail_d = push_s ? (tail_q + PW'(1)) : tail_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards anything still queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    assign st_ready = !full_s;
    assign empty    = empty_s;
    assign count    = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts
// every cycle's outputs and a negedge monitor compares them.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        mem_write;
        logic        mem_read;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        ld_hit;
        logic        ld_stall;
        logic [15:0] ld_data;
        logic [2:0]  cnt;
        logic        st_ready;
        logic        empty;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } st_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [15:0] st_addr = 16'h0;
    logic [15:0] st_data = 16'h0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [15:0] ld_data;
    logic        ld_hit;
    logic        ld_stall;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    logic [15:0] env_mem [256];
    logic [15:0] ref_mem [256];
    exp_t        exp_q [$];
    st_t         sq [$];
    int          n_chk = 0;
    int          n_fail = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_hit    (ld_hit),
        .ld_stall  (ld_stall),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_init(input int a);
        logic [7:0] b;
        b = 8'(a);
        return (a == 8'h40) ? 16'h5A5A : {~b, b};
    endfunction

    // Data memory model that the DUT actually talks to.
    assign mem_rdata = env_mem[mem_addr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) env_mem[i] = mem_init(i);
        forever begin
            @(posedge clk);
            if (mem_write) env_mem[mem_addr[7:0]] = mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, predict outputs, advance the model.
    task automatic cycle(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                         input logic lv, input logic [15:0] la);
        exp_t        e;
        bit          full;
        bit          hit;
        bit          rd;
        logic [15:0] hd;
        @(posedge clk);
        #1;
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
        full = (sq.size() == DEPTH);
        hit  = 1'b0;
        hd   = 16'h0;
        if (lv) begin
            for (int i = sq.size() - 1; i >= 0; i--) begin
                if (sq[i].a == la) begin
                    hit = 1'b1;
                    hd  = sq[i].d;
                    break;
                end
            end
        end
        rd = lv && !hit && !full;
        e.ld_hit    = hit;
        e.ld_stall  = lv && !hit && full;
        e.ld_data   = hit ? hd : (rd ? ref_mem[la[7:0]] : 16'h0);
        e.mem_read  = rd;
        e.mem_write = !rd && (sq.size() > 0);
        e.mem_addr  = rd ? la : (e.mem_write ? sq[0].a : 16'h0);
        e.mem_wdata = e.mem_write ? sq[0].d : 16'h0;
        e.cnt       = 3'(sq.size());
        e.st_ready  = !full;
        e.empty     = (sq.size() == 0);
        exp_q.push_back(e);
        if (e.mem_write) begin
            ref_mem[sq[0].a[7:0]] = sq[0].d;
            void'(sq.pop_front());
        end
        if (sv && !full) sq.push_back('{a: sa, d: sd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    // Monitor: compare every predicted cycle against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_write", 32'(mem_write), 32'(e.mem_write));
            chk("mem_read",  32'(mem_read),  32'(e.mem_read));
            chk("mem_addr",  32'(mem_addr),  32'(e.mem_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.mem_wdata));
            chk("ld_hit",    32'(ld_hit),    32'(e.ld_hit));
            chk("ld_stall",  32'(ld_stall),  32'(e.ld_stall));
            chk("ld_data",   32'(ld_data),   32'(e.ld_data));
            chk("count",     32'(count),     32'(e.cnt));
            chk("st_ready",  32'(st_ready),  32'(e.st_ready));
            chk("empty",     32'(empty),     32'(e.empty));
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_ld_hit", 32'(ld_hit), 32'd0);
        chk("rst_ld_stall", 32'(ld_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single store drains the following cycle.
        cycle(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
        idle(1);
        #1;
        chk("drain_write", 32'(mem_write), 32'd1);
        chk("drain_addr", 32'(mem_addr), 32'h0010);
        chk("drain_data", 32'(mem_wdata), 32'hBEEF);
        idle(1);
        #1;
        chk("drain_empty", 32'(empty), 32'd1);

        // Youngest-match forwarding.
        cycle(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0030);
        cycle(1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0030);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        #1;
        chk("fwd_hit", 32'(ld_hit), 32'd1);
        chk("fwd_data", 32'(ld_data), 32'h2222);
        idle(2);

        // Load miss beats drain.
        cycle(1'b1, 16'h0050, 16'h00A1, 1'b1, 16'h0030);
        cycle(1'b1, 16'h0052, 16'h00A2, 1'b1, 16'h0030);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0040);
        #1;
        chk("lbd_read", 32'(mem_read), 32'd1);
        chk("lbd_data", 32'(ld_data), 32'h5A5A);
        chk("lbd_nowrite", 32'(mem_write), 32'd0);
        chk("lbd_count", 32'(count), 32'd2);

        // Fill to full, stall a missing load, then retry.
        cycle(1'b1, 16'h0054, 16'h00A3, 1'b1, 16'h0030);
        cycle(1'b1, 16'h0056, 16'h00A4, 1'b1, 16'h0030);
        cycle(1'b1, 16'h0058, 16'h00A5, 1'b1, 16'h0032);
        #1;
        chk("full_st_ready", 32'(st_ready), 32'd0);
        chk("full_stall", 32'(ld_stall), 32'd1);
        chk("full_drain_addr", 32'(mem_addr), 32'h0050);
        cycle(1'b1, 16'h0058, 16'h00A5, 1'b1, 16'h0032);
        #1;
        chk("retry_st_ready", 32'(st_ready), 32'd1);
        chk("retry_read", 32'(mem_read), 32'd1);
        idle(6);

        // Pointer wrap-around with interleaved loads.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'(16'h0060 + i), 16'(16'h0100 + i), 1'(i % 3 == 0), 16'(16'h005F + i));
        end
        idle(6);

        // Asynchronous reset with three stores queued.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'(16'h0070 + i), 16'(16'hC000 + i), 1'b1, 16'h0030);
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_mem_write", 32'(mem_write), 32'd0);
        sq.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'(16'h0010 + $urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 9) < 4), 16'(16'h0010 + $urandom_range(0, 8)));
        end
        idle(8);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 256; i++) chk($sformatf("mem[%0h]", i), 32'(env_mem[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
